// File: rtl/l1_cache_pkg.sv
// l1_cache_pkg: shared state encoding, line geometry and address-field widths for the L1 data cache.
package l1_cache_pkg;
  localparam int LINE_BITS = 128;
  localparam int OFFSET_BITS = 4;
  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;
  function automatic int index_bits(input int num_lines);
    return $clog2(num_lines);
  endfunction
  function automatic int tag_bits(input int num_lines);
    return 32 - OFFSET_BITS - $clog2(num_lines);
  endfunction
endpackage

// File: rtl/cache_line_store.sv
// cache_line_store: direct-mapped valid/dirty/tag/data arrays with one async read port and one word-or-line write port.
module cache_line_store
  import l1_cache_pkg::*;
#(
  parameter int NUM_LINES = 64,
  parameter int IW = 6,
  parameter int TW = 22
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [IW-1:0]        rd_index,
  output logic                 rd_valid,
  output logic                 rd_dirty,
  output logic [TW-1:0]        rd_tag,
  output logic [LINE_BITS-1:0] rd_line,
  input  logic [IW-1:0]        wr_index,
  input  logic                 wr_word_en,
  input  logic [1:0]           wr_word,
  input  logic [31:0]          wr_wdata,
  input  logic                 wr_line_en,
  input  logic [TW-1:0]        wr_tag,
  input  logic [LINE_BITS-1:0] wr_line
);
  logic [NUM_LINES-1:0] valid, dirty;
  logic [TW-1:0] tags [NUM_LINES];
  logic [LINE_BITS-1:0] data [NUM_LINES];
  assign rd_valid = valid[rd_index];
  assign rd_dirty = dirty[rd_index];
  assign rd_tag = tags[rd_index];
  assign rd_line = data[rd_index];
  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= '0;
      dirty <= '0;
    end else if (wr_line_en) begin
      valid[wr_index] <= 1'b1;
      dirty[wr_index] <= 1'b0;
    end else if (wr_word_en) begin
      dirty[wr_index] <= 1'b1;
    end
  end
  // Tags and data carry no reset; valid alone qualifies them.
  always_ff @(posedge clock) begin
    if (wr_line_en) begin
      tags[wr_index] <= wr_tag;
      data[wr_index] <= wr_line;
    end else if (wr_word_en) begin
      data[wr_index][{wr_word, 5'b0} +: 32] <= wr_wdata;
    end
  end
endmodule

// File: rtl/l1_dcache.sv
// l1_dcache: direct-mapped write-back, write-allocate L1 data cache with a blocking miss FSM.
module l1_dcache
  import l1_cache_pkg::*;
#(
  parameter int NUM_LINES = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cpu_rd,
  input  logic                 cpu_wr,
  input  logic [31:0]          cpu_addr,
  input  logic [31:0]          cpu_wdata,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_stall,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [LINE_BITS-1:0] mem_wdata,
  input  logic [LINE_BITS-1:0] mem_rdata,
  input  logic                 mem_ack
);
  localparam int IW = index_bits(NUM_LINES);
  localparam int TW = tag_bits(NUM_LINES);
  localparam int WW = $clog2(WORDS_PER_LINE);
  state_t state, state_n;
  logic [IW-1:0] index;
  logic [TW-1:0] tag, v_tag;
  logic [WW-1:0] word;
  logic v_valid, v_dirty, hit, req, idle, load_hit, store_hit, fill, unused_ok;
  logic [LINE_BITS-1:0] v_line;
  assign index = cpu_addr[IW+OFFSET_BITS-1:OFFSET_BITS];
  assign tag = cpu_addr[31:IW+OFFSET_BITS];
  assign word = cpu_addr[WW+1:2];
  assign unused_ok = &{1'b0, cpu_addr[1:0]};
  assign hit = v_valid && v_tag == tag;
  assign req = cpu_rd || cpu_wr;
  assign idle = state == IDLE;
  assign store_hit = idle && cpu_wr && hit;
  assign load_hit = idle && cpu_rd && !cpu_wr && hit;
  assign fill = state == ALLOCATE && mem_ack;
  cache_line_store #(.NUM_LINES(NUM_LINES), .IW(IW), .TW(TW)) u_store (
    .clock(clock), .reset(reset),
    .rd_index(index), .rd_valid(v_valid), .rd_dirty(v_dirty), .rd_tag(v_tag), .rd_line(v_line),
    .wr_index(index), .wr_word_en(store_hit), .wr_word(word), .wr_wdata(cpu_wdata),
    .wr_line_en(fill), .wr_tag(tag), .wr_line(mem_rdata)
  );
  always_ff @(posedge clock) state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:      state_n = req && !hit ? (v_valid && v_dirty ? WRITEBACK : ALLOCATE) : IDLE;
      WRITEBACK: state_n = mem_ack ? ALLOCATE : WRITEBACK;
      ALLOCATE:  state_n = mem_ack ? IDLE : ALLOCATE;
      default:   state_n = IDLE;
    endcase
  end
  // The held CPU address keeps index/tag, and hence the request, stable while stalled.
  assign cpu_stall = !idle || (req && !hit);
  assign mem_req = !idle;
  assign mem_we = state == WRITEBACK;
  assign mem_addr = state == WRITEBACK ? {v_tag, index, {OFFSET_BITS{1'b0}}}
                  : state == ALLOCATE  ? {tag, index, {OFFSET_BITS{1'b0}}} : '0;
  assign mem_wdata = state == WRITEBACK ? v_line : '0;
  assign cpu_rdata = load_hit ? v_line[{word, 5'b0} +: 32] : '0;
endmodule

// File: tb/tb_l1_dcache.sv
// tb_l1_dcache: directed vectors and miss/reset sequences against a latency-configurable line memory.
module tb_l1_dcache;
  logic clock = 1'b0, reset, cpu_rd, cpu_wr, cpu_stall, mem_req, mem_we, mem_ack;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic [127:0] mem [logic [31:0]];
  logic [127:0] rd_auto = '0, rd_force = '0;
  logic ack_auto = 1'b0, ack_force = 1'b0;
  bit auto_ack = 1'b1;
  int lat = 3, cnt = 0, errors = 0, checks = 0;

  l1_dcache dut (
    .clock(clock), .reset(reset), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  always #5 clock = ~clock;
  assign mem_ack = auto_ack ? ack_auto : ack_force;
  assign mem_rdata = auto_ack ? rd_auto : rd_force;

  // Line memory: acks in the lat-th cycle of a request.
  always @(negedge clock) begin
    if (reset) begin
      ack_auto = 1'b0;
      cnt = 0;
    end else if (ack_auto) begin
      ack_auto = 1'b0;
      cnt = mem_req ? 1 : 0;
    end else if (mem_req) begin
      cnt++;
      if (cnt >= lat) begin
        ack_auto = 1'b1;
        if (mem_we) mem[mem_addr] = mem_wdata;
        else rd_auto = mem.exists(mem_addr) ? mem[mem_addr] : '0;
      end
    end
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    @(posedge clock);
    #1;
    cpu_rd = rd;
    cpu_wr = wr;
    cpu_addr = a;
    cpu_wdata = d;
  endtask

  task automatic sample();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_unstall(output int n, output int wb_n, output logic [31:0] wb_addr,
                              output logic [31:0] al_addr, output logic [127:0] wb_data,
                              output int unstable);
    logic pr, pw, pk;
    logic [31:0] pa;
    logic [127:0] pd;
    n = 0; wb_n = 0; wb_addr = '0; al_addr = '0; wb_data = '0; unstable = 0;
    pr = 1'b0; pw = 1'b0; pk = 1'b0; pa = '0; pd = '0;
    sample();
    while (cpu_stall && n < 60) begin
      n++;
      if (mem_req && mem_we) begin
        wb_n++;
        wb_addr = mem_addr;
        wb_data = mem_wdata;
      end
      if (mem_req && !mem_we) al_addr = mem_addr;
      if (pr && !pk && (!mem_req || mem_we !== pw || mem_addr !== pa || mem_wdata !== pd)) unstable++;
      pr = mem_req; pw = mem_we; pa = mem_addr; pd = mem_wdata; pk = mem_ack;
      sample();
    end
    check("stall_bound", n < 60, 1);
  endtask

  typedef struct {
    logic rd;
    logic wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic exp_stall;
  } vec_t;

  initial begin
    vec_t vecs[9];
    int n, wb_n, unstable, reissued;
    logic [31:0] wb_addr, al_addr;
    logic [127:0] wb_data;
    vecs[0] = '{1'b0, 1'b1, 32'h44, 32'hDEADBEEF, 32'h0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h44, 32'h0, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h40, 32'h0, 32'h1111, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h48, 32'h0, 32'h3333, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'h4C, 32'h0, 32'h4444, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 32'h48, 32'hCAFEF00D, 32'h0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 32'h48, 32'h0, 32'hCAFEF00D, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 32'h43, 32'h0, 32'h1111, 1'b0};
    mem[32'h40] = 128'h00004444_00003333_00002222_00001111;
    mem[32'h440] = 128'h0000BBB3_0000BBB2_0000BBB1_0000BBB0;
    reset = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    sample();
    check("rst_stall", cpu_stall, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rdata", cpu_rdata, 0);

    drive(1'b1, 1'b0, 32'h40, 32'h0);
    wait_unstall(n, wb_n, wb_addr, al_addr, wb_data, unstable);
    check("cold_stall_cycles", n, 4);
    check("cold_no_wb", wb_n, 0);
    check("cold_alloc_addr", al_addr, 32'h40);
    check("cold_stable", unstable, 0);
    check("cold_rdata", cpu_rdata, 32'h1111);
    check("cold_req_drop", mem_req, 0);

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      sample();
      check($sformatf("vec%0d_rdata", i), cpu_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_stall", i), cpu_stall, vecs[i].exp_stall);
      check($sformatf("vec%0d_mem_req", i), mem_req, 0);
    end

    drive(1'b0, 1'b0, 32'h0, 32'h0);
    auto_ack = 1'b0; ack_force = 1'b1; rd_force = '1;
    sample();
    check("idle_ack_stall", cpu_stall, 0);
    @(posedge clock);
    #1 ack_force = 1'b0; auto_ack = 1'b1; rd_force = '0;
    sample();
    check("idle_ack_no_req", mem_req, 0);
    drive(1'b1, 1'b0, 32'h40, 32'h0);
    sample();
    check("idle_ack_line_kept", cpu_rdata, 32'h1111);
    check("idle_ack_hit", cpu_stall, 0);

    drive(1'b1, 1'b0, 32'h440, 32'h0);
    wait_unstall(n, wb_n, wb_addr, al_addr, wb_data, unstable);
    check("evict_stall_cycles", n, 7);
    check("evict_wb_cycles", wb_n, 3);
    check("evict_wb_addr", wb_addr, 32'h40);
    check("evict_wb_word1", wb_data[63:32], 32'hDEADBEEF);
    check("evict_wb_line", wb_data, 128'h00004444_CAFEF00D_DEADBEEF_00001111);
    check("evict_alloc_addr", al_addr, 32'h440);
    check("evict_stable", unstable, 0);
    check("evict_rdata", cpu_rdata, 32'hBBB0);
    check("evict_req_drop", mem_req, 0);

    drive(1'b1, 1'b0, 32'h48, 32'h0);
    wait_unstall(n, wb_n, wb_addr, al_addr, wb_data, unstable);
    check("clean_evict_cycles", n, 4);
    check("clean_evict_no_wb", wb_n, 0);
    check("refetch_rdata", cpu_rdata, 32'hCAFEF00D);

    lat = 10;
    drive(1'b1, 1'b0, 32'h80, 32'h0);
    sample();
    check("miss_comb_stall", cpu_stall, 1);
    check("miss_first_no_req", mem_req, 0);
    sample();
    check("alloc_req", mem_req, 1);
    check("alloc_we", mem_we, 0);
    check("alloc_addr", mem_addr, 32'h80);
    sample();
    @(posedge clock);
    #1 reset = 1'b1; cpu_rd = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;
    sample();
    check("midrst_mem_req", mem_req, 0);
    check("midrst_stall", cpu_stall, 0);
    check("midrst_mem_we", mem_we, 0);
    check("midrst_mem_addr", mem_addr, 0);
    check("midrst_mem_wdata", mem_wdata, 0);
    check("midrst_rdata", cpu_rdata, 0);
    reissued = 0;
    repeat (4) begin
      sample();
      if (mem_req) reissued++;
    end
    check("no_reissue", reissued, 0);
    lat = 3;
    drive(1'b1, 1'b0, 32'h40, 32'h0);
    wait_unstall(n, wb_n, wb_addr, al_addr, wb_data, unstable);
    check("post_rst_miss_cycles", n, 4);
    check("post_rst_no_wb", wb_n, 0);
    check("post_rst_rdata", cpu_rdata, 32'h1111);

    drive(1'b0, 1'b1, 32'h94, 32'h12345678);
    wait_unstall(n, wb_n, wb_addr, al_addr, wb_data, unstable);
    check("store_miss_cycles", n, 4);
    check("store_miss_alloc_addr", al_addr, 32'h90);
    check("store_miss_rdata", cpu_rdata, 0);
    drive(1'b1, 1'b0, 32'h94, 32'h0);
    sample();
    check("store_miss_readback", cpu_rdata, 32'h12345678);
    drive(1'b1, 1'b0, 32'h90, 32'h0);
    sample();
    check("store_miss_other_word", cpu_rdata, 0);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    sample();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
